// File: rtl/radix4_div_pkg.sv
// Shared state encoding and constants for the radix-4 sequential divider.
package radix4_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int DEF_WIDTH = 16;

  // Wide enough for any legal WIDTH; users slice [WIDTH-1:0].
  localparam logic [63:0] SAT_ONES = '1;

endpackage

// File: rtl/radix4_div_digit.sv
// Radix-4 restoring digit selection: largest k in 0..3 with rp - k*d >= 0.
// Purely combinational; expects rp < 4*d so the next remainder fits WIDTH bits.
module radix4_div_digit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH+1:0] rp,
  input  logic [WIDTH-1:0] d,
  output logic [1:0]       q,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH+2:0] ext, d1, d2, d3;
  logic [WIDTH+2:0] t1, t2, t3;
  logic             unused_bits;

  // One guard bit above rp/3d makes the sign of each trial exact.
  assign ext = {1'b0, rp};
  assign d1  = {3'b000, d};
  assign d2  = {2'b00, d, 1'b0};
  assign d3  = d1 + d2;

  assign t1 = ext - d1;
  assign t2 = ext - d2;
  assign t3 = ext - d3;

  // A non-negative trial is below d, so its upper bits are always zero.
  assign unused_bits = ^{t1[WIDTH+1:WIDTH], t2[WIDTH+1:WIDTH], t3[WIDTH+1:WIDTH]};

  always_comb begin
    q      = 2'd0;
    r_next = rp[WIDTH-1:0];
    if (!t3[WIDTH+2]) begin
      q      = 2'd3;
      r_next = t3[WIDTH-1:0];
    end else if (!t2[WIDTH+2]) begin
      q      = 2'd2;
      r_next = t2[WIDTH-1:0];
    end else if (!t1[WIDTH+1+1]) begin
      q      = 2'd1;
      r_next = t1[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/radix4_seq_divider.sv
// Sequential 2W/W radix-4 divider with ovf/dz flags; RADIX4_DIV_SIGNED_EN selects two's-complement operands.
// done pulses ITER+2 edges after accept (1 edge on dz/ovf early exit); start is ignored while busy.
module radix4_seq_divider
  import radix4_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf,
  output logic               dz
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0]    LAST = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] SAT  = SAT_ONES[WIDTH-1:0];

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_reg, rem_r, shf, quo;
  logic [WIDTH-1:0] q_res, r_res;
  logic             ovf_res, dz_res;

  logic [2*WIDTH-1:0] a_mag;
  logic [WIDTH-1:0]   d_mag;
  logic               div_zero, pre_ovf;

  logic [WIDTH+1:0] rp;
  logic [1:0]       digit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] fix_q, fix_r;
  logic             fix_ovf;

`ifdef RADIX4_DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
  logic sgn_q, sgn_r;

  // 2W-bit magnitude keeps the most-negative dividend representable.
  always_comb begin
    a_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
    d_mag = divisor[WIDTH-1] ? -divisor : divisor;
  end

  always_comb begin
    fix_ovf = sgn_q ? (quo > MIN_MAG) : quo[WIDTH-1];
    fix_q   = sgn_q ? -quo : quo;
    fix_r   = sgn_r ? -rem_r : rem_r;
  end
`else
  assign a_mag   = dividend;
  assign d_mag   = divisor;
  assign fix_ovf = 1'b0;
  assign fix_q   = quo;
  assign fix_r   = rem_r;
`endif

  assign div_zero = (divisor == '0);
  // High half already >= divisor means the quotient needs more than WIDTH bits.
  assign pre_ovf  = (a_mag[2*WIDTH-1:WIDTH] >= d_mag);

  assign rp = {rem_r, shf[WIDTH-1:WIDTH-2]};

  radix4_div_digit #(.WIDTH(WIDTH)) u_digit (
    .rp     (rp),
    .d      (d_reg),
    .q      (digit),
    .r_next (rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (div_zero || pre_ovf) ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      d_reg     <= '0;
      rem_r     <= '0;
      shf       <= '0;
      quo       <= '0;
      q_res     <= '0;
      r_res     <= '0;
      ovf_res   <= 1'b0;
      dz_res    <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
`ifdef RADIX4_DIV_SIGNED_EN
      sgn_q     <= 1'b0;
      sgn_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            d_reg   <= d_mag;
            rem_r   <= a_mag[2*WIDTH-1:WIDTH];
            shf     <= a_mag[WIDTH-1:0];
            quo     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
            dz_res  <= div_zero;
            ovf_res <= !div_zero && pre_ovf;
            q_res   <= SAT;
            r_res   <= div_zero ? dividend[WIDTH-1:0] : '0;
`ifdef RADIX4_DIV_SIGNED_EN
            sgn_q   <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            sgn_r   <= dividend[2*WIDTH-1];
`endif
          end
        end
        CALC: begin
          rem_r <= rem_nxt;
          shf   <= {shf[WIDTH-3:0], 2'b00};
          quo   <= {quo[WIDTH-3:0], digit};
          cnt   <= cnt + CW'(1);
        end
        FIX: begin
          ovf_res <= fix_ovf;
          q_res   <= fix_ovf ? SAT : fix_q;
          r_res   <= fix_ovf ? '0 : fix_r;
        end
        DONE: begin
          done      <= 1'b1;
          quotient  <= q_res;
          remainder <= r_res;
          ovf       <= ovf_res;
          dz        <= dz_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_seq_divider.sv
// Self-checking bench for radix4_seq_divider (WIDTH=16), directed cases plus randomized regression.
// Follows RADIX4_DIV_SIGNED_EN for operand interpretation.
module tb_radix4_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done;
  logic [15:0] quotient, remainder;
  logic        ovf, dz;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  radix4_seq_divider #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  // Reference: plain integer division of the operands as numbers.
  function automatic void model(input logic [31:0] a, input logic [15:0] d,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic eovf, output logic edz, output int lat);
    longint na, nd, nq, nr, lo, hi, mq;
`ifdef RADIX4_DIV_SIGNED_EN
    na = longint'($signed(a));
    nd = longint'($signed(d));
    lo = -32768;
    hi = 32767;
`else
    na = longint'(a);
    nd = longint'(d);
    lo = 0;
    hi = 65535;
`endif
    eovf = 1'b0;
    edz  = 1'b0;
    if (nd == 0) begin
      edz = 1'b1;
      q   = 16'hFFFF;
      r   = a[15:0];
      lat = 1;
    end else begin
      nq = na / nd;
      nr = na % nd;
      mq = (nq < 0) ? -nq : nq;
      if (nq < lo || nq > hi) begin
        eovf = 1'b1;
        q    = 16'hFFFF;
        r    = 16'h0000;
        lat  = (mq >= 65536) ? 1 : 10;
      end else begin
        q   = nq[15:0];
        r   = nr[15:0];
        lat = 10;
      end
    end
  endfunction

  // Called just after a posedge with the DUT idle; lat = edges from accept to done.
  task automatic do_op(input logic [31:0] a, input logic [15:0] d,
                       output int lat, output logic busy_acc);
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    busy_acc = busy;
    lat      = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 16'h0) begin errors++; $display("FAIL reset_quotient got=%h exp=0000", quotient); end
    checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder got=%h exp=0000", remainder); end
    checks++; if ({ovf, dz} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {ovf, dz}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

`ifndef RADIX4_DIV_SIGNED_EN
  task automatic test_unsigned_basic;
    int lat;
    logic b;
    do_op(32'd100000, 16'd7, lat, b);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL busy_after_accept got=%b exp=1", b); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL latency_normal got=%0d exp=10", lat); end
    checks++; if (quotient !== 16'h37CD) begin errors++; $display("FAIL div7_quotient got=%h exp=37cd", quotient); end
    checks++; if (remainder !== 16'd5) begin errors++; $display("FAIL div7_remainder got=%h exp=0005", remainder); end
    checks++; if ({ovf, dz} !== 2'b00) begin errors++; $display("FAIL div7_flags got=%b exp=00", {ovf, dz}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single_cycle got=%b exp=0", done); end
    checks++; if (quotient !== 16'h37CD) begin errors++; $display("FAIL quotient_held got=%h exp=37cd", quotient); end
    do_op(32'hFFFE0001, 16'hFFFF, lat, b);
    checks++; if ({quotient, remainder, ovf} !== {16'hFFFF, 16'h0000, 1'b0})
      begin errors++; $display("FAIL max_operands got q=%h r=%h ovf=%b exp q=ffff r=0000 ovf=0", quotient, remainder, ovf); end
  endtask
`else
  task automatic test_signed_basic;
    int lat;
    logic b;
    do_op(32'hFFFE7960, 16'd7, lat, b);
    checks++; if (lat !== 10) begin errors++; $display("FAIL latency_normal got=%0d exp=10", lat); end
    checks++; if ({quotient, remainder, ovf, dz} !== {16'hC833, 16'hFFFB, 2'b00})
      begin errors++; $display("FAIL neg_dividend got q=%h r=%h exp q=c833 r=fffb", quotient, remainder); end
    do_op(32'd100000, 16'hFFF9, lat, b);
    checks++; if ({quotient, remainder, ovf, dz} !== {16'hC833, 16'h0005, 2'b00})
      begin errors++; $display("FAIL neg_divisor got q=%h r=%h exp q=c833 r=0005", quotient, remainder); end
    do_op(32'h00008000, 16'd1, lat, b);
    checks++; if ({quotient, remainder, ovf, lat} !== {16'hFFFF, 16'h0000, 1'b1, 32'd10})
      begin errors++; $display("FAIL pos_range_ovf got q=%h r=%h ovf=%b lat=%0d exp q=ffff r=0000 ovf=1 lat=10", quotient, remainder, ovf, lat); end
    do_op(32'hFFFF8000, 16'd1, lat, b);
    checks++; if ({quotient, remainder, ovf} !== {16'h8000, 16'h0000, 1'b0})
      begin errors++; $display("FAIL most_neg_quotient got q=%h r=%h ovf=%b exp q=8000 r=0000 ovf=0", quotient, remainder, ovf); end
    do_op(32'h80000000, 16'hFFFF, lat, b);
    checks++; if ({quotient, ovf, lat} !== {16'hFFFF, 1'b1, 32'd1})
      begin errors++; $display("FAIL most_neg_dividend got q=%h ovf=%b lat=%0d exp q=ffff ovf=1 lat=1", quotient, ovf, lat); end
  endtask
`endif

  task automatic test_early_exit;
    int lat;
    logic b;
    do_op(32'h00070000, 16'd7, lat, b);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency got=%0d exp=1", lat); end
    checks++; if ({quotient, remainder, ovf, dz} !== {16'hFFFF, 16'h0000, 2'b10})
      begin errors++; $display("FAIL ovf_result got q=%h r=%h ovf=%b dz=%b exp q=ffff r=0000 ovf=1 dz=0", quotient, remainder, ovf, dz); end
    do_op(32'd1234, 16'd0, lat, b);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    checks++; if ({quotient, remainder, ovf, dz} !== {16'hFFFF, 16'd1234, 2'b01})
      begin errors++; $display("FAIL dz_result got q=%h r=%h ovf=%b dz=%b exp q=ffff r=04d2 ovf=0 dz=1", quotient, remainder, ovf, dz); end
    dividend = 32'd100000; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({ovf, dz} !== 2'b00) begin errors++; $display("FAIL flags_clear_on_accept got=%b exp=00", {ovf, dz}); end
    checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL quotient_held_busy got=%h exp=ffff", quotient); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++; if (lat !== 10 || quotient !== 16'h37CD)
      begin errors++; $display("FAIL after_flags got q=%h lat=%0d exp q=37cd lat=10", quotient, lat); end
  endtask

  task automatic test_busy_ignore;
    int lat, busy_cycles;
    dividend = 32'd100000; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 32'h12345678; divisor = 16'h0003;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start = (k >= 2 && k <= 4);
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    start = 1'b0;
    checks++; if (lat !== 10) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=10", lat); end
    checks++; if ({quotient, remainder} !== {16'h37CD, 16'd5})
      begin errors++; $display("FAIL busy_ignore_result got q=%h r=%h exp q=37cd r=0005", quotient, remainder); end
    busy_cycles = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy) busy_cycles++;
    end
    checks++; if (busy_cycles !== 0) begin errors++; $display("FAIL start_not_queued busy_cycles=%0d exp=0", busy_cycles); end
  endtask

  task automatic test_reset_abort;
    int lat, dones;
    logic b;
    logic [15:0] eq, er;
    logic eo, ed;
    int el;
    dividend = 32'd100000; divisor = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done, quotient, remainder, ovf, dz} !== 36'h0)
      begin errors++; $display("FAIL abort_outputs got busy=%b done=%b q=%h r=%h exp all zero", busy, done, quotient, remainder); end
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    model(32'd987654321, 16'd40000, eq, er, eo, ed, el);
    do_op(32'd987654321, 16'd40000, lat, b);
    checks++; if ({quotient, remainder, ovf, dz} !== {eq, er, eo, ed} || lat !== el)
      begin errors++; $display("FAIL after_abort got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d", quotient, remainder, lat, eq, er, el); end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [15:0] d, hi, eq, er;
    logic [23:0] s24;
    logic        eo, ed, b;
    int          lat, el, mode;
    longint      na, nd, sq, sr;
    for (int i = 0; i < 3000; i++) begin
      mode = $urandom_range(0, 7);
      d    = 16'($urandom);
      if (mode == 0) d = 16'h0;
      if (mode == 1) begin
        a = $urandom;
      end else if (mode == 2) begin
        s24 = 24'($urandom);
        a   = {{8{s24[23]}}, s24};
      end else begin
        hi = (d == 16'h0) ? 16'($urandom) : 16'($urandom % d);
        a  = {hi, 16'($urandom)};
      end
      model(a, d, eq, er, eo, ed, el);
      do_op(a, d, lat, b);
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL rand_busy a=%h d=%h got=%b exp=1", a, d, b); end
      checks++; if ({quotient, remainder, ovf, dz} !== {eq, er, eo, ed})
        begin errors++; $display("FAIL rand_result a=%h d=%h got q=%h r=%h ovf=%b dz=%b exp q=%h r=%h ovf=%b dz=%b",
                                 a, d, quotient, remainder, ovf, dz, eq, er, eo, ed); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rand_latency a=%h d=%h got=%0d exp=%0d", a, d, lat, el); end
      if (!eo && !ed) begin
`ifdef RADIX4_DIV_SIGNED_EN
        na = longint'($signed(a));
        nd = longint'($signed(d));
        sq = longint'($signed(quotient));
        sr = longint'($signed(remainder));
        checks++;
        if (na != sq * nd + sr || (sr != 0 && ((sr < 0) != (na < 0))) ||
            ((sr < 0) ? -sr : sr) >= ((nd < 0) ? -nd : nd))
          begin errors++; $display("FAIL rand_invariant a=%h d=%h got q=%h r=%h", a, d, quotient, remainder); end
`else
        na = longint'(a);
        nd = longint'(d);
        sq = longint'(quotient);
        sr = longint'(remainder);
        checks++;
        if (na != sq * nd + sr || sr >= nd)
          begin errors++; $display("FAIL rand_invariant a=%h d=%h got q=%h r=%h", a, d, quotient, remainder); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef RADIX4_DIV_SIGNED_EN
    test_unsigned_basic();
`else
    test_signed_basic();
`endif
    test_early_exit();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
